// File: rtl/egg_timer_pkg.sv
// Shared state encodings and BCD limits for the egg timer controller.
// Rev 1.0 - initial release.
`default_nettype none

package egg_timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_PAUSE = 2'b10,
    ST_ALARM = 2'b11
  } state_e;

  localparam logic [3:0] BCD_MAX_ONES   = 4'd9;
  localparam logic [3:0] BCD_MAX_TENS   = 4'd5;
  localparam int         DEF_MAX_MIN    = 59;
  localparam int         DEF_ALARM_SECS = 30;

endpackage

`default_nettype wire

// File: rtl/bcd_digit.sv
// Single BCD digit register with clear, increment and decrement that wrap at a programmable maximum.
// Rev 1.0 - initial release.
`default_nettype none

module bcd_digit (
  input  logic       clk,
  input  logic       reset,
  input  logic       load_zero,
  input  logic       inc,
  input  logic       dec,
  input  logic [3:0] max_val,
  output logic       wrap,
  output logic [3:0] value
);

  logic [3:0] value_q, value_d;
  logic       at_max, at_zero;

  assign at_max  = (value_q == max_val);
  assign at_zero = (value_q == 4'd0);

  // Carry on increment from max, borrow on decrement from zero.
  assign wrap  = (inc && at_max) || (dec && at_zero);
  assign value = value_q;

  always_comb begin
    value_d = value_q;
    if (load_zero) begin
      value_d = 4'd0;
    end else if (inc) begin
      value_d = at_max ? 4'd0 : value_q + 4'd1;
    end else if (dec) begin
      value_d = at_zero ? max_val : value_q - 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      value_q <= 4'd0;
    end else begin
      value_q <= value_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/egg_timer_ctrl.sv
// Egg timer controller: MM:SS BCD countdown with IDLE/RUN/PAUSE/ALARM FSM.
// Optional macro EGG_ALARM_TIMEOUT_EN adds ALARM auto-clear after ALARM_SECS ticks. Rev 1.0.
`default_nettype none

module egg_timer_ctrl #(
  parameter int MAX_MIN    = egg_timer_pkg::DEF_MAX_MIN,
  parameter int ALARM_SECS = egg_timer_pkg::DEF_ALARM_SECS
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick_1hz,
  input  logic       start_p,
  input  logic       inc_min_p,
  input  logic       inc_sec_p,
  input  logic       clear_p,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       running,
  output logic       alarm,
  output logic [1:0] state
);

  import egg_timer_pkg::*;

  localparam logic [3:0] MAX_MIN_TENS = 4'(MAX_MIN / 10);
  localparam logic [3:0] MAX_MIN_ONES = 4'(MAX_MIN % 10);

  state_e state_q, state_d;
  logic   running_q, alarm_q;

  logic [3:0] mt_val, mo_val, st_val, so_val;
  logic       mt_wrap, mo_wrap, st_wrap, so_wrap;

  // Priority qualification: clear > start > tick > increments.
  logic w_tick, w_inc_ok;
  assign w_tick   = !clear_p && !start_p && tick_1hz;
  assign w_inc_ok = !clear_p && !start_p && !tick_1hz;

  logic w_time_zero, w_time_one, w_min_at_max;
  assign w_time_zero  = (mt_val == 4'd0) && (mo_val == 4'd0) &&
                        (st_val == 4'd0) && (so_val == 4'd0);
  assign w_time_one   = (mt_val == 4'd0) && (mo_val == 4'd0) &&
                        (st_val == 4'd0) && (so_val == 4'd1);
  assign w_min_at_max = (mt_val == MAX_MIN_TENS) && (mo_val == MAX_MIN_ONES);

  logic w_dec, w_inc_sec, w_inc_min, w_min_clear, w_underflow;
  assign w_dec       = (state_q == ST_RUN) && w_tick;
  assign w_inc_sec   = (state_q == ST_IDLE) && w_inc_ok && inc_sec_p;
  assign w_inc_min   = (state_q == ST_IDLE) && w_inc_ok && inc_min_p;
  assign w_min_clear = clear_p || (w_inc_min && w_min_at_max);
  // A borrow out of the minutes is unreachable; treated as expiry for safety.
  assign w_underflow = w_dec && mt_wrap;

  bcd_digit u_sec_ones (
    .clk       (clk),
    .reset     (reset),
    .load_zero (clear_p),
    .inc       (w_inc_sec),
    .dec       (w_dec),
    .max_val   (BCD_MAX_ONES),
    .wrap      (so_wrap),
    .value     (so_val)
  );

  bcd_digit u_sec_tens (
    .clk       (clk),
    .reset     (reset),
    .load_zero (clear_p),
    .inc       (w_inc_sec && so_wrap),
    .dec       (w_dec && so_wrap),
    .max_val   (BCD_MAX_TENS),
    .wrap      (st_wrap),
    .value     (st_val)
  );

  bcd_digit u_min_ones (
    .clk       (clk),
    .reset     (reset),
    .load_zero (w_min_clear),
    .inc       (w_inc_min && !w_min_at_max),
    .dec       (w_dec && so_wrap && st_wrap),
    .max_val   (BCD_MAX_ONES),
    .wrap      (mo_wrap),
    .value     (mo_val)
  );

  bcd_digit u_min_tens (
    .clk       (clk),
    .reset     (reset),
    .load_zero (w_min_clear),
    .inc       (w_inc_min && !w_min_at_max && mo_wrap),
    .dec       (w_dec && so_wrap && st_wrap && mo_wrap),
    .max_val   (BCD_MAX_ONES),
    .wrap      (mt_wrap),
    .value     (mt_val)
  );

  logic w_alarm_timeout;

`ifdef EGG_ALARM_TIMEOUT_EN
  localparam logic [5:0] ALARM_LAST = 6'(ALARM_SECS - 1);

  logic [5:0] alarm_cnt_q, alarm_cnt_d;

  assign w_alarm_timeout = (state_q == ST_ALARM) && w_tick && (alarm_cnt_q == ALARM_LAST);

  always_comb begin
    alarm_cnt_d = alarm_cnt_q;
    if ((state_q != ST_ALARM) && (state_d == ST_ALARM)) begin
      alarm_cnt_d = 6'd0;
    end else if ((state_q == ST_ALARM) && w_tick) begin
      alarm_cnt_d = alarm_cnt_q + 6'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      alarm_cnt_q <= 6'd0;
    end else begin
      alarm_cnt_q <= alarm_cnt_d;
    end
  end
`else
  assign w_alarm_timeout = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    if (clear_p) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_p && !w_time_zero) state_d = ST_RUN;
        end
        ST_RUN: begin
          if (start_p)                                  state_d = ST_PAUSE;
          else if (w_dec && (w_time_one || w_underflow)) state_d = ST_ALARM;
        end
        ST_PAUSE: begin
          if (start_p) state_d = ST_RUN;
        end
        ST_ALARM: begin
          if (start_p || w_alarm_timeout) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      running_q <= 1'b0;
      alarm_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      running_q <= (state_d == ST_RUN);
      alarm_q   <= (state_d == ST_ALARM);
    end
  end

  assign min_tens = mt_val;
  assign min_ones = mo_val;
  assign sec_tens = st_val;
  assign sec_ones = so_val;
  assign running  = running_q;
  assign alarm    = alarm_q;
  assign state    = state_q;

endmodule

`default_nettype wire
